id_hazard_ctrl: RTL

Interlock controller for the 5-stage MIPS pipeline, sitting beside the instruction-decode stage. It keeps a shadow scoreboard of in-flight destination registers (EX, MEM) and compares them against the sources of the instruction in ID. From that comparison it drives the PC/IF-ID write enables, the ID/EX bubble and the IF/ID flush. It also sequences branch-taken flushes and counts stall cycles for performance debug.

---
 rtl/id_hazard_ctrl.sv | 84 ++++++++
 1 files changed

// File: rtl/id_hazard_ctrl.sv
// id_hazard_ctrl: ID-stage interlock with an EX/MEM destination-tag scoreboard, branch flush sequencing and stall counter.
// Define HAZARD_FORWARDING_EN when the forwarding unit exists, so that only load-use hazards stall.
module id_hazard_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             ID_Valid,
    input  logic [4:0]       ID_Rs,
    input  logic [4:0]       ID_Rt,
    input  logic             ID_UsesRs,
    input  logic             ID_UsesRt,
    input  logic [4:0]       ID_WriteReg,
    input  logic             ID_RegWrite,
    input  logic             ID_MemRead,
    input  logic             EX_BranchTaken,
    output logic             PCWrite,
    output logic             IFIDWrite,
    output logic             IFIDFlush,
    output logic             IDEXBubble,
    output logic             Stall,
    output logic [1:0]       State,
    output logic [CNT_W-1:0] StallCycles
);
    typedef enum logic [1:0] {RUN = 2'b00, STALL = 2'b01, FLUSH = 2'b10} stateT;
    stateT curState, nxtState;
    logic exV, exRw, exMr;
    logic [4:0] exReg;
    logic rsHaz, rtHaz, hazard, branch;
`ifdef HAZARD_FORWARDING_EN
    assign rsHaz = exV & exRw & exMr & (exReg == ID_Rs);
    assign rtHaz = exV & exRw & exMr & (exReg == ID_Rt);
`else
    logic memV, memRw;
    logic [4:0] memReg;
    logic unusedMr;
    assign unusedMr = exMr;
    assign rsHaz = (exV & exRw & (exReg == ID_Rs)) | (memV & memRw & (memReg == ID_Rs));
    assign rtHaz = (exV & exRw & (exReg == ID_Rt)) | (memV & memRw & (memReg == ID_Rt));
`endif
    // Gating with Reset keeps the strobes at their idle values while reset is held.
    assign hazard = Reset & ID_Valid &
                    ((ID_UsesRs & rsHaz & (|ID_Rs)) | (ID_UsesRt & rtHaz & (|ID_Rt)));
    assign branch = Reset & EX_BranchTaken;
    assign Stall = hazard & ~branch;
    assign PCWrite = ~Stall;
    assign IFIDWrite = ~Stall;
    assign IFIDFlush = branch;
    assign IDEXBubble = branch | Stall;
    assign State = curState;

    always_comb begin
        nxtState = RUN;
        nxtState = branch ? FLUSH : Stall ? STALL : RUN;
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            exV <= 1'b0;
            exRw <= 1'b0;
            exMr <= 1'b0;
            exReg <= 5'd0;
`ifndef HAZARD_FORWARDING_EN
            memV <= 1'b0;
            memRw <= 1'b0;
            memReg <= 5'd0;
`endif
            curState <= RUN;
            StallCycles <= '0;
        end else begin
            exV <= ID_Valid & ~IDEXBubble;
            exRw <= ID_RegWrite & ~IDEXBubble;
            exMr <= ID_MemRead & ~IDEXBubble;
            exReg <= IDEXBubble ? 5'd0 : ID_WriteReg;
`ifndef HAZARD_FORWARDING_EN
            memV <= exV;
            memRw <= exRw;
            memReg <= exReg;
`endif
            curState <= nxtState;
            if (Stall && StallCycles != '1) StallCycles <= StallCycles + 1'b1;
        end
    end
endmodule
